pattern_feeder: RTL and testbench
=================================

Name: pattern_feeder

Overview:
- Input-side counterpart to the seg-display classifier: captures a 3x3 binary pixel pattern from board switches and streams it into the BP network as fixed-point samples.
- Transfer starts on a debounced start-key press.
- After the last pixel, waits for the network's frame_done, the same strobe that enables the display latch.
- Sits between board I/O and the network input port.

Parameters:
- NPIX, 9, pixels per frame (3x3, row-major).
- DATA_W, 10, sample width; matches the network result width.
- PIX_HI, 10'd1023, sample value for a lit pixel.
- PIX_LO, 10'd0, sample value for a dark pixel.
- DB_MAX, 20'd999999, debounce stable-count limit (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sw  in  9  pixel switches; sw[8] = top-left, sw[0] = bottom-right.
- key_start  in  1  raw start button, active-low, asynchronous to clk.
- pix_data  out  DATA_W  current pixel sample.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  network accepts sample.
- pix_last  out  1  final pixel of frame, qualified by pix_valid.
- frame_done  in  1  one-cycle network completion strobe.
- busy  out  1  high from capture until frame_done.

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on posedge clk.
- Reset values: pix_data=0, pix_valid=0, pix_last=0, busy=0. FSM goes to IDLE, idx=0, shadow=0, debounce state cleared.
- Reset mid-transfer aborts the frame at the next edge; no partial resume.
- Debounce:
  - key_start passes through a 2-FF synchronizer.
  - Counter increments while the synced level differs from the stable level; clears otherwise.
  - At DB_MAX the stable level flips and the counter clears.
  - A stable 1->0 transition produces a one-cycle start pulse.
- FSM states: IDLE, SEND, WAIT.
- IDLE: on start pulse, shadow<=sw, idx<=0, busy<=1, go to SEND. pix_valid asserts the next cycle.
- SEND:
  - pix_valid=1; pix_data = shadow[NPIX-1-idx] ? PIX_HI : PIX_LO; pix_last = (idx==NPIX-1).
  - Handshake occurs on pix_valid&&pix_ready. If not last: idx++, stay in SEND. If last: pix_valid<=0, pix_last<=0, go to WAIT.
  - While pix_valid&&!pix_ready, pix_data and pix_last hold stable.
  - pix_valid never drops before a handshake.
  - With pix_ready held high, one pixel transfers per cycle: 9 cycles per frame.
- WAIT: busy=1. On frame_done, busy<=0 and go to IDLE.
- Boundary conditions:
  - frame_done in IDLE or SEND is ignored.
  - Start pulses in SEND or WAIT are ignored, not queued.
  - sw changes after capture do not affect the frame in flight.
  - idx is a 4-bit counter; it never exceeds NPIX-1 and resets to 0 on each capture.
  - If a start pulse and frame_done coincide in WAIT, the FSM returns to IDLE; that start pulse is dropped.

Optional Feature:
- Macro: PRESET_PATTERN_EN.
- Defined:
  - If sw[8]=1 at capture, shadow loads a built-in pattern selected by sw[1:0] instead of sw.
  - Presets: 0 -> Z 9'b111_010_111; 1 -> V 9'b101_101_010; 2 -> N 9'b101_111_101; 3 -> all-dark 9'b0.
  - If sw[8]=0, shadow loads sw as usual.
- Undefined: shadow always loads sw directly, and no preset logic is built.

Decomposition:
- Shared package bp_pkg holds:
  - FSM state enum {IDLE, SEND, WAIT};
  - NPIX;
  - PIX_HI/PIX_LO defaults;
  - preset constants PAT_Z, PAT_V, PAT_N, also consumed by the display-side bench.
- One sub-module: key_debounce (synchronizer, counter, falling-edge pulse; parameter DB_MAX).

Test Plan (bench sets DB_MAX=4):
- sw=9'b101_010_101, key held low 10 cycles, pix_ready=1 -> start pulse after sync+4 stable cycles; 9 beats 1023,0,1023,0,1023,0,1023,0,1023; pix_last only on beat 9; busy=1 until frame_done.
- Backpressure: pix_ready low on beat 3 for 5 cycles -> pix_data holds 1023 (bit6=1 in pattern above), pix_valid stays 1, idx stays 2, no beat dropped; total 9 handshakes.
- Key bounce: key_start toggles every 2 cycles for 20 cycles then releases high -> no start pulse, busy stays 0.
- Second press while in WAIT, and sw changed to 9'h1FF mid-SEND -> no new frame; the in-flight frame keeps its captured pattern; after frame_done the next press sends nine 1023s.
- rst_n low for 1 cycle at beat 5 -> next cycle pix_valid=0, busy=0, FSM in IDLE; a later press restarts from beat 1.
- PRESET_PATTERN_EN defined, sw=9'b1_0000_0001 -> beats follow V 101_101_010: 1023,0,1023,1023,0,1023,0,1023,0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the pattern feeder and its display-side counterpart:
// feeder FSM states, frame geometry, sample defaults and the preset glyphs.
package bp_pkg;

  localparam int NPIX = 9;
  localparam int IDX_W = 4;

  localparam logic [9:0] PIX_HI_DEF = 10'd1023;
  localparam logic [9:0] PIX_LO_DEF = 10'd0;

  localparam logic [NPIX-1:0] PAT_Z    = 9'b111_010_111;
  localparam logic [NPIX-1:0] PAT_V    = 9'b101_101_010;
  localparam logic [NPIX-1:0] PAT_N    = 9'b101_111_101;
  localparam logic [NPIX-1:0] PAT_DARK = 9'b000_000_000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } feed_state_t;

  function automatic logic [NPIX-1:0] preset_pattern(input logic [1:0] sel);
    case (sel)
      2'd0:    preset_pattern = PAT_Z;
      2'd1:    preset_pattern = PAT_V;
      2'd2:    preset_pattern = PAT_N;
      default: preset_pattern = PAT_DARK;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Start-key conditioner: 2-FF synchronizer, stable-count debounce and a
// one-cycle pulse on the debounced press (stable 1->0).
module key_debounce #(
  parameter logic [19:0] DB_MAX = 20'd999999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic start_pulse
);

  logic        sync_q1;
  logic        sync_q2;
  logic        stable_q;
  logic [19:0] cnt_q;

  // Debounce state resets to the released (high) key level so no press is implied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      stable_q    <= 1'b1;
      cnt_q       <= '0;
      start_pulse <= 1'b0;
    end else begin
      sync_q1     <= key_n;
      sync_q2     <= sync_q1;
      start_pulse <= 1'b0;
      if (sync_q2 != stable_q) begin
        if (cnt_q == DB_MAX) begin
          stable_q    <= sync_q2;
          cnt_q       <= '0;
          start_pulse <= stable_q;
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/pattern_feeder.sv
// Captures a 3x3 switch pattern on a debounced start press and streams it as
// fixed-point samples with a valid/ready handshake. Optional: PRESET_PATTERN_EN.
module pattern_feeder
  import bp_pkg::*;
#(
  parameter int                DATA_W = 10,
  parameter logic [DATA_W-1:0] PIX_HI = PIX_HI_DEF,
  parameter logic [DATA_W-1:0] PIX_LO = PIX_LO_DEF,
  parameter logic [19:0]       DB_MAX = 20'd999999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPIX-1:0]   sw,
  input  logic              key_start,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  input  logic              frame_done,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  feed_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic [NPIX-1:0]   shadow_q, shadow_d;
  logic [NPIX-1:0]   capture_pat;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, last_d, busy_d;
  logic              start_pulse;

  key_debounce #(.DB_MAX(DB_MAX)) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_start),
    .start_pulse(start_pulse)
  );

`ifdef PRESET_PATTERN_EN
  assign capture_pat = sw[8] ? preset_pattern(sw[1:0]) : sw;
`else
  assign capture_pat = sw;
`endif

  // Row-major: index 0 is the top-left pixel, held in the MSB.
  function automatic logic [DATA_W-1:0] pix_sample(input logic [NPIX-1:0] pat,
                                                   input logic [IDX_W-1:0] i);
    pix_sample = pat[LAST_IDX - i] ? PIX_HI : PIX_LO;
  endfunction

  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    data_d   = pix_data;
    valid_d  = pix_valid;
    last_d   = pix_last;
    busy_d   = busy;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          shadow_d = capture_pat;
          idx_d    = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b1;
          data_d   = pix_sample(capture_pat, '0);
          last_d   = (LAST_IDX == '0);
          state_d  = SEND;
        end
      end
      SEND: begin
        if (pix_valid && pix_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = WAIT;
          end else begin
            idx_d  = idx_inc;
            data_d = pix_sample(shadow_q, idx_inc);
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      WAIT: begin
        if (frame_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      pix_data  <= data_d;
      pix_valid <= valid_d;
      pix_last  <= last_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pattern_feeder.sv
// Directed bench for pattern_feeder with a short debounce limit (DB_MAX=4).
module tb_pattern_feeder;
  import bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] sw = 9'b0;
  logic       key_start = 1'b1;
  logic [9:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b0;
  logic       pix_last;
  logic       frame_done = 1'b0;
  logic       busy;

  int n_tests = 0;
  int n_fail = 0;

  logic [9:0] beat_data [16];
  logic       beat_last [16];
  int         nbeats;

  int exp_alt [9] = '{1023, 0, 1023, 0, 1023, 0, 1023, 0, 1023};
  int exp_all [9] = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
  int exp_v   [9] = '{1023, 0, 1023, 1023, 0, 1023, 0, 1023, 0};

  pattern_feeder #(
    .DATA_W(10),
    .PIX_HI(10'd1023),
    .PIX_LO(10'd0),
    .DB_MAX(20'd4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .key_start (key_start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic press_key();
    @(negedge clk);
    key_start = 1'b0;
    repeat (12) @(negedge clk);
    key_start = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic collect_frame(input int max_cycles);
    nbeats = 0;
    for (int c = 0; c < max_cycles && nbeats < 9; c++) begin
      @(negedge clk);
      pix_ready = 1'b1;
      if (pix_valid) begin
        beat_data[nbeats] = pix_data;
        beat_last[nbeats] = pix_last;
        nbeats++;
      end
    end
  endtask

  task automatic pulse_frame_done();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (pix_valid !== 1'b0 || pix_last !== 1'b0 || busy !== 1'b0 || pix_data !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b data=%0d, required 0 0 0 0",
               pix_valid, pix_last, busy, pix_data);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", pix_valid, busy);
    end
  endtask

  task automatic test_frame();
    sw = 9'b101_010_101;
    pix_ready = 1'b0;
    press_key();
    n_tests++;
    if (pix_valid !== 1'b1 || busy !== 1'b1 || pix_last !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_start: valid=%b busy=%b last=%b, required 1 1 0",
               pix_valid, busy, pix_last);
    end
    collect_frame(40);
    n_tests++;
    if (nbeats !== 9) begin
      n_fail++;
      $display("FAIL frame_beats: got %0d beats, required 9", nbeats);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_alt[k] || beat_last[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL frame_beat%0d: data=%0d last=%b, required %0d %b",
                 k + 1, beat_data[k], beat_last[k], exp_alt[k], (k == 8));
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wait: valid=%b busy=%b, required 0 1", pix_valid, busy);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold: busy=%b, required 1", busy);
    end
    pulse_frame_done();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_clear: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int stall_cnt;
    sw = 9'b101_010_101;
    pix_ready = 1'b0;
    press_key();
    nbeats = 0;
    stall_cnt = 0;
    for (int c = 0; c < 80 && nbeats < 9; c++) begin
      @(negedge clk);
      if (nbeats == 2 && stall_cnt < 5) begin
        pix_ready = 1'b0;
        frame_done = (stall_cnt == 0);
        n_tests++;
        if (pix_valid !== 1'b1 || pix_data !== 10'd1023 || pix_last !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold%0d: valid=%b data=%0d last=%b busy=%b, required 1 1023 0 1",
                   stall_cnt, pix_valid, pix_data, pix_last, busy);
        end
        stall_cnt++;
      end else begin
        pix_ready = 1'b1;
        frame_done = 1'b0;
        if (pix_valid) begin
          beat_data[nbeats] = pix_data;
          beat_last[nbeats] = pix_last;
          nbeats++;
        end
      end
    end
    frame_done = 1'b0;
    n_tests++;
    if (nbeats !== 9 || stall_cnt !== 5) begin
      n_fail++;
      $display("FAIL bp_handshakes: beats=%0d stalls=%0d, required 9 5", nbeats, stall_cnt);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_alt[k] || beat_last[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: data=%0d last=%b, required %0d %b",
                 k + 1, beat_data[k], beat_last[k], exp_alt[k], (k == 8));
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    pulse_frame_done();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_bounce();
    int viol;
    viol = 0;
    pix_ready = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      key_start = (i < 20) ? ((i >> 1) % 2 == 1) : 1'b1;
      if (pix_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL bounce: %0d cycles with valid/busy set, required 0", viol);
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_wait_ignore();
    int viol;
    sw = 9'b101_010_101;
    pix_ready = 1'b0;
    press_key();
    sw = 9'h1FF;
    collect_frame(40);
    n_tests++;
    if (nbeats !== 9) begin
      n_fail++;
      $display("FAIL inflight_beats: got %0d, required 9", nbeats);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_alt[k]) begin
        n_fail++;
        $display("FAIL inflight_beat%0d: data=%0d, required %0d", k + 1, beat_data[k], exp_alt[k]);
      end
    end
    viol = 0;
    key_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 12) key_start = 1'b1;
      if (pix_valid !== 1'b0 || busy !== 1'b1) viol++;
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL press_in_wait: %0d bad cycles, required 0", viol);
    end
    pix_ready = 1'b0;
    pulse_frame_done();
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_queued_start: busy=%b valid=%b, required 0 0", busy, pix_valid);
    end
    press_key();
    collect_frame(40);
    n_tests++;
    if (nbeats !== 9) begin
      n_fail++;
      $display("FAIL allon_beats: got %0d, required 9", nbeats);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_all[k]) begin
        n_fail++;
        $display("FAIL allon_beat%0d: data=%0d, required %0d", k + 1, beat_data[k], exp_all[k]);
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    pulse_frame_done();
  endtask

  task automatic test_reset_mid();
    int viol;
    sw = 9'b101_010_101;
    pix_ready = 1'b0;
    press_key();
    nbeats = 0;
    for (int c = 0; c < 40 && nbeats < 4; c++) begin
      @(negedge clk);
      pix_ready = 1'b1;
      if (pix_valid) nbeats++;
    end
    @(negedge clk);
    n_tests++;
    if (pix_valid !== 1'b1 || pix_data !== 10'd1023) begin
      n_fail++;
      $display("FAIL beat5_present: valid=%b data=%0d, required 1 1023", pix_valid, pix_data);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || pix_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b busy=%b last=%b, required 0 0 0", pix_valid, busy, pix_last);
    end
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL no_resume: %0d bad cycles, required 0", viol);
    end
    pix_ready = 1'b0;
    press_key();
    collect_frame(40);
    n_tests++;
    if (nbeats !== 9) begin
      n_fail++;
      $display("FAIL restart_beats: got %0d, required 9", nbeats);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_alt[k] || beat_last[k] !== (k == 8)) begin
        n_fail++;
        $display("FAIL restart_beat%0d: data=%0d last=%b, required %0d %b",
                 k + 1, beat_data[k], beat_last[k], exp_alt[k], (k == 8));
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    pulse_frame_done();
  endtask

`ifdef PRESET_PATTERN_EN
  task automatic test_preset();
    sw = 9'b1_0000_0001;
    pix_ready = 1'b0;
    press_key();
    collect_frame(40);
    n_tests++;
    if (nbeats !== 9) begin
      n_fail++;
      $display("FAIL preset_beats: got %0d, required 9", nbeats);
    end
    for (int k = 0; k < nbeats && k < 9; k++) begin
      n_tests++;
      if (int'(beat_data[k]) !== exp_v[k]) begin
        n_fail++;
        $display("FAIL preset_beat%0d: data=%0d, required %0d", k + 1, beat_data[k], exp_v[k]);
      end
    end
    @(negedge clk);
    pix_ready = 1'b0;
    pulse_frame_done();
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_bounce();
    test_wait_ignore();
    test_reset_mid();
`ifdef PRESET_PATTERN_EN
    test_preset();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
